// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision helpers for the FP issue/writeback wrappers.
// The override record is common to every wrapper that short-circuits special
// operands around its arithmetic pipeline.
`timescale 1ns/1ps
package fp_pkg;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    // Result forced by operand classification instead of the arithmetic unit.
    typedef struct packed {
        logic        ovr;
        logic [31:0] val;
    } fp_ovr_t;

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] x);
        return (x[30:23] == FP_EXP_MAX) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic fp_is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

endpackage

// File: rtl/fp_special_case.sv
// Classifies an add's operands at issue time and decides whether the result
// is fixed by IEEE special cases (NaN, Inf, zeros, exact cancellation).
// When ovr_o.ovr is set, ovr_o.val replaces whatever fpadd produces.
`timescale 1ns/1ps
module fp_special_case
    import fp_pkg::*;
(
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output fp_ovr_t     ovr_o
);

    logic nan1;
    logic nan2;
    logic inf1;
    logic inf2;
    logic zero1;
    logic zero2;
    logic sign_diff;
    logic mag_equal;

    assign nan1      = fp_is_nan(rs1_i);
    assign nan2      = fp_is_nan(rs2_i);
    assign inf1      = fp_is_inf(rs1_i);
    assign inf2      = fp_is_inf(rs2_i);
    assign zero1     = fp_is_zero(rs1_i);
    assign zero2     = fp_is_zero(rs2_i);
    assign sign_diff = rs1_i[31] ^ rs2_i[31];
    assign mag_equal = rs1_i[30:0] == rs2_i[30:0];

    // Priority chain: earlier rules shadow later ones.
    always_comb begin
        ovr_o = '0;
        if (nan1 || nan2 || (inf1 && inf2 && sign_diff)) begin
            ovr_o.ovr = 1'b1;
            ovr_o.val = FP_QNAN;
        end else if (inf1) begin
            ovr_o.ovr = 1'b1;
            ovr_o.val = rs1_i;
        end else if (inf2) begin
            ovr_o.ovr = 1'b1;
            ovr_o.val = rs2_i;
        end else if (zero1 && zero2) begin
            // -0 only when both operands are -0
            ovr_o.ovr = 1'b1;
            ovr_o.val = {rs1_i[31] & rs2_i[31], 31'd0};
        end else if (zero1) begin
            ovr_o.ovr = 1'b1;
            ovr_o.val = rs2_i;
        end else if (zero2) begin
            ovr_o.ovr = 1'b1;
            ovr_o.val = rs1_i;
        end else if (mag_equal && sign_diff) begin
            // x + (-x) is +0 in round-to-nearest
            ovr_o.ovr = 1'b1;
            ovr_o.val = 32'd0;
        end
    end

endmodule

// File: rtl/fpadd_wb_ctrl.sv
// Issue/writeback wrapper around a fixed-latency fpadd pipeline.
// Issue fires drive fpadd directly; a delay line of matching depth carries
// valid, tag and the special-case override so that on exit the correct result
// (override or fpadd output) is pushed into a small FIFO feeding writeback.
// Credits (FIFO occupancy + ops in flight) gate issue so the FIFO cannot
// overflow and fpadd never needs a stall.
`timescale 1ns/1ps
module fpadd_wb_ctrl
    import fp_pkg::*;
#(
    parameter int ADD_LAT    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [31:0]      iss_rs1,
    input  logic [31:0]      iss_rs2,
    input  logic [TAG_W-1:0] iss_tag,
    output logic [31:0]      fa_rs1,
    output logic [31:0]      fa_rs2,
    input  logic [31:0]      fa_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    // One delay-line slot travelling alongside the fpadd pipeline.
    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        fp_ovr_t          ovr;
    } stage_t;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    fp_ovr_t iss_ovr;
    logic    iss_fire;

    fp_special_case u_special (
        .rs1_i (iss_rs1),
        .rs2_i (iss_rs2),
        .ovr_o (iss_ovr)
    );

    // fpadd runs every cycle; it is the delay-line valid that marks real ops.
    assign fa_rs1   = iss_rs1;
    assign fa_rs2   = iss_rs2;
    assign iss_fire = iss_valid & iss_ready;

    // ------------------------------------------------------------------
    // Delay line matched to the fpadd depth
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ADD_LAT; gi++) begin : g_stage
            stage_t st_q;
            stage_t st_d;

            if (gi == 0) begin : g_head
                assign st_d = '{vld: iss_fire, tag: iss_tag, ovr: iss_ovr};
            end else begin : g_tail
                assign st_d = g_stage[gi-1].st_q;
            end

            // Advance unconditionally: fpadd has no stall, so neither do we.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    st_q <= '0;
                end else begin
                    st_q <= st_d;
                end
            end
        end
    endgenerate

    stage_t      exit_st;
    logic        push;
    logic [31:0] push_data;

    assign exit_st   = g_stage[ADD_LAT-1].st_q;
    assign push      = exit_st.vld;
    assign push_data = exit_st.ovr.ovr ? exit_st.ovr.val : fa_out;

    // ------------------------------------------------------------------
    // Result FIFO and credit bookkeeping
    // ------------------------------------------------------------------
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag_q  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;
    logic             pop;

    assign pop = wb_valid & wb_ready;

    // Next-state for pointers and counters; simultaneous +1/-1 cancel out.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case ({iss_fire, push})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    // Control state; reset discards everything in flight or queued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Payload storage; stale contents are harmless because count gates wb_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_tag_q[wr_ptr_q]  <= exit_st.tag;
        end
    end

    // Head slot is never overwritten while occupied, so wb_* hold under backpressure.
    assign wb_valid  = count_q != '0;
    assign wb_data   = fifo_data_q[rd_ptr_q];
    assign wb_tag    = fifo_tag_q[rd_ptr_q];
    assign busy      = (inflight_q != '0) || (count_q != '0);
    assign iss_ready = ({1'b0, count_q} + {1'b0, inflight_q}) < CREDIT_MAX;

endmodule
